frame_ram_arbiter: RTL and testbench
====================================

// Module: frame_ram_arbiter
// PURPOSE
//  Shares the single-port frame RAM (4096 x 16, two 2048-word frames) between two requesters:
//  requester 0 = frame blitter (RAM -> VRAM copy, timer-driven), requester 1 = host/keyboard writer.
//  Round-robin grant with bounded burst length, owner-muxed RAM port, read-return tagging.
//  Sits between the requesters and the frame RAM inference block; RAM read latency is 1 cycle.
// PARAMETERS
//  ADDR_W     12  frame RAM address width
//  DATA_W     16  frame RAM data width
//  MAX_BURST  64  max consecutive beats one owner may take while the other is requesting (2..256)
// PORTS
//  CLK         in   1        system clock; all state on rising edge
//  RESET_N     in   1        asynchronous, active-low reset
//  REQ         in   2        per-requester request; held high for the whole burst
//  WE          in   2        per-requester write enable for the current beat
//  ADDR0/ADDR1 in   ADDR_W   per-requester beat address
//  WDATA0/1    in   DATA_W   per-requester write data
//  GNT         out  2        one-hot/zero grant; a beat occurs on any cycle with GNT[n] & REQ[n]
//  RVALID      out  1        read data valid on RDATA, one cycle after a read beat
//  RVALID_ID   out  1        requester that issued the returning read
//  RDATA       out  DATA_W   = RAM_DOUT (pass-through)
//  RAM_EN      out  1        to RAM: enable
//  RAM_WE      out  1        to RAM: write
//  RAM_ADDR    out  ADDR_W   to RAM: address
//  RAM_DIN     out  DATA_W   to RAM: write data
//  RAM_DOUT    in   DATA_W   from RAM: registered read data
// BEHAVIOUR
//  - Reset (async, RESET_N=0): state=IDLE, GNT=0, RVALID=0, RVALID_ID=0, beat count=0, rr pointer=0
//    (requester 0 preferred first). In-flight read return is dropped; RAM_EN=0 immediately.
//  - States: IDLE, OWN0, OWN1. GNT is registered: GNT[n]=1 exactly in OWNn.
//  - IDLE: no REQ -> IDLE. One REQ -> OWN of it. Both -> OWN of requester not last served (rr ptr).
//    IDLE->OWNn costs one cycle; first beat is in the cycle GNT rises (REQ still high).
//  - OWNn, REQ[n]=1: beat. RAM_EN=1, RAM_WE=WE[n], RAM_ADDR=ADDRn, RAM_DIN=WDATAn (combinational mux).
//    Beat count increments (saturates at MAX_BURST-1).
//  - OWNn, REQ[n]=0: no beat (RAM_EN=0); next = OWN(other) if other REQ else IDLE; count cleared.
//  - OWNn, beat with count==MAX_BURST-1 and other REQ=1: forced handover, next = OWN(other),
//    count cleared. If other not requesting, owner keeps grant and count holds saturated.
//  - Handover OWN0<->OWN1 is direct (no IDLE cycle); rr ptr records last owner on every exit.
//  - Outside OWNn with REQ: RAM_EN=RAM_WE=0, RAM_ADDR/RAM_DIN = 0.
//  - Read beat (RAM_EN & ~RAM_WE) at cycle t -> RVALID=1, RVALID_ID=n at t+1; RDATA valid then.
//    Write beats never raise RVALID. Back-to-back reads give RVALID on consecutive cycles.
//  - REQ dropped same cycle as forced handover: treated as release (no beat), handover still occurs.
//  - Non-granted requester's WE/ADDR/WDATA are ignored; it must hold REQ until GNT.
// CONFIGURATION
//  FRAME_RAM_FIXED_PRIO_EN defined: requester 0 always wins in IDLE and may preempt requester 1
//    at any beat boundary (OWN1 with REQ[0]=1 -> OWN0 next cycle, OWN1's beat still taken);
//    requester 0 bursts are unbounded (MAX_BURST applies only to requester 1). rr pointer unused.
//  Not defined: round-robin + MAX_BURST bound for both, as above.
// STRUCTURE
//  Package frame_ram_arb_pkg: state encoding (IDLE/OWN0/OWN1), requester IDs REQ_BLIT=0, REQ_HOST=1,
//    BURST_W = $clog2(MAX_BURST) helper function.
//  Sub-module frame_ram_arb_pick: combinational next-owner selection from REQ, rr ptr, current owner,
//    burst-expired flag (macro-aware). Counter, state reg, RAM mux and read-tag pipe stay in top.
// TESTING
//  1 Reset: hold RESET_N=0 with REQ=2'b11 -> GNT=0, RAM_EN=0, RVALID=0; release -> GNT=2'b01 in 1 cycle.
//  2 Single read burst: REQ0 high 4 cycles, WE0=0, ADDR0=0x800..0x803 -> 4 RAM_EN beats,
//    RVALID_ID=0 on 4 consecutive cycles one later, RDATA equals preloaded RAM[0x800..0x803].
//  3 Burst bound (MAX_BURST=4): REQ0 continuous, REQ1 rises at beat 2 -> exactly 4 beats for 0,
//    GNT=2'b10 next cycle with no idle gap; REQ1 held 3 beats -> GNT back to 2'b01.
//  4 Release: REQ1 drops mid-burst with REQ0=0 -> RAM_EN=0 that cycle, IDLE, GNT=0 next cycle.
//  5 Write then read: host writes 0xBEEF to 0x123, then blitter reads 0x123 -> RDATA=0xBEEF, RVALID_ID=0.
//  6 FRAME_RAM_FIXED_PRIO_EN: OWN1 streaming, REQ0 rises -> GNT=2'b01 next cycle; REQ0 held
//    100 beats with REQ1 high -> GNT never returns to 1 until REQ0 drops.

Source files
------------

// File: rtl/frame_ram_arb_pkg.sv
// frame_ram_arb_pkg: owner-state encoding, requester IDs and burst-counter
// width helper shared by the frame RAM arbiter and its next-owner picker.
package frame_ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Requester 0 is the frame blitter, requester 1 the host/keyboard writer.
  localparam logic REQ_BLIT = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  // Width of a counter that must hold 0 .. max_burst-1.
  function automatic int unsigned burst_w(input int unsigned max_burst);
    int unsigned w;
    w = $clog2(max_burst);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/frame_ram_arb_pick.sv
// frame_ram_arb_pick: combinational next-owner selection for the frame RAM
// arbiter. Round-robin with a burst bound by default; with
// FRAME_RAM_FIXED_PRIO_EN defined the blitter always wins and may preempt
// the host at any beat boundary.
module frame_ram_arb_pick
  import frame_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_pref,
  input  arb_state_e state,
  input  logic       burst_expired,
  output arb_state_e next_state
);

`ifdef FRAME_RAM_FIXED_PRIO_EN
  // Fixed priority needs neither the rr pointer nor the blitter burst bound.
  logic [1:0] unused_inputs;
  assign unused_inputs = {rr_pref, burst_expired};
`endif

  // Next owner from the requests, the current owner and the burst state.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req == 2'b11) begin
`ifdef FRAME_RAM_FIXED_PRIO_EN
          next_state = ST_OWN0;
`else
          next_state = rr_pref ? ST_OWN1 : ST_OWN0;
`endif
        end else if (req[REQ_BLIT]) begin
          next_state = ST_OWN0;
        end else if (req[REQ_HOST]) begin
          next_state = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!req[REQ_BLIT]) begin
          next_state = req[REQ_HOST] ? ST_OWN1 : ST_IDLE;
        end
`ifndef FRAME_RAM_FIXED_PRIO_EN
        else if (burst_expired && req[REQ_HOST]) begin
          next_state = ST_OWN1;
        end
`endif
      end
      ST_OWN1: begin
        if (!req[REQ_HOST]) begin
          next_state = req[REQ_BLIT] ? ST_OWN0 : ST_IDLE;
        end
`ifdef FRAME_RAM_FIXED_PRIO_EN
        else if (req[REQ_BLIT]) begin
          next_state = ST_OWN0;
        end
`else
        else if (burst_expired && req[REQ_BLIT]) begin
          next_state = ST_OWN0;
        end
`endif
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter: shares the single-port 4096x16 frame RAM between the
// frame blitter (requester 0) and the host writer (requester 1). Registered
// one-hot grant, owner-muxed RAM port, bounded bursts and read-return tagging.
// Optional build macro: FRAME_RAM_FIXED_PRIO_EN (blitter fixed priority).
module frame_ram_arbiter
  import frame_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [1:0]        REQ,
  input  logic [1:0]        WE,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic [1:0]        GNT,
  output logic              RVALID,
  output logic              RVALID_ID,
  output logic [DATA_W-1:0] RDATA,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DIN,
  input  logic [DATA_W-1:0] RAM_DOUT
);

  localparam int unsigned         BURST_W    = burst_w(MAX_BURST);
  localparam logic [BURST_W-1:0]  BURST_LAST = BURST_W'(MAX_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [BURST_W-1:0] count_q, count_d;
  logic               rr_pref_q, rr_pref_d;
  logic               rvalid_q, rvalid_d;
  logic               rvalid_id_q, rvalid_id_d;

  logic               owned;
  logic               owner;
  logic               beat;
  logic               burst_expired;
  logic               ram_en;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_din;

  // Who owns the RAM and whether that owner takes a beat this cycle.
  always_comb begin
    owned         = (state_q != ST_IDLE);
    owner         = (state_q == ST_OWN1) ? REQ_HOST : REQ_BLIT;
    beat          = owned && REQ[owner];
    burst_expired = (count_q == BURST_LAST);
  end

  // RAM port mux: the owner's beat passes straight through, otherwise quiet.
  always_comb begin
    ram_en   = beat;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (beat) begin
      ram_we = WE[owner];
      if (owner == REQ_HOST) begin
        ram_addr = ADDR1;
        ram_din  = WDATA1;
      end else begin
        ram_addr = ADDR0;
        ram_din  = WDATA0;
      end
    end
  end

  frame_ram_arb_pick u_pick (
    .req           (REQ),
    .rr_pref       (rr_pref_q),
    .state         (state_q),
    .burst_expired (burst_expired),
    .next_state    (state_d)
  );

  // Burst counter and round-robin preference, both updated on owner change.
  // rr_pref holds the requester to favour next, i.e. the complement of the
  // last owner, so its reset value of 0 favours the blitter first.
  always_comb begin
    count_d   = count_q;
    rr_pref_d = rr_pref_q;
    if (state_d != state_q) begin
      count_d = '0;
      if (owned) begin
        rr_pref_d = ~owner;
      end
    end else if (beat && !burst_expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Read-return tag: a read beat now returns data and its owner next cycle.
  always_comb begin
    rvalid_d    = ram_en && !ram_we;
    rvalid_id_d = rvalid_d ? owner : rvalid_id_q;
  end

  // State, counter, preference and read-tag registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rr_pref_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rvalid_id_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rr_pref_q   <= rr_pref_d;
      rvalid_q    <= rvalid_d;
      rvalid_id_q <= rvalid_id_d;
    end
  end

  assign GNT       = {state_q == ST_OWN1, state_q == ST_OWN0};
  assign RVALID    = rvalid_q;
  assign RVALID_ID = rvalid_id_q;
  assign RDATA     = RAM_DOUT;
  assign RAM_EN    = ram_en;
  assign RAM_WE    = ram_we;
  assign RAM_ADDR  = ram_addr;
  assign RAM_DIN   = ram_din;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// tb_frame_ram_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model of
// the arbitration rules and a golden copy of the frame RAM contents.
module tb_frame_ram_arbiter;

  localparam int MB = 4;
`ifdef FRAME_RAM_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [1:0]  REQ = 2'b00;
  logic [1:0]  WE = 2'b00;
  logic [11:0] ADDR0 = '0;
  logic [11:0] ADDR1 = '0;
  logic [15:0] WDATA0 = '0;
  logic [15:0] WDATA1 = '0;
  logic [1:0]  GNT;
  logic        RVALID;
  logic        RVALID_ID;
  logic [15:0] RDATA;
  logic        RAM_EN;
  logic        RAM_WE;
  logic [11:0] RAM_ADDR;
  logic [15:0] RAM_DIN;
  logic [15:0] ram_dout;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  frame_ram_arbiter #(
    .ADDR_W    (12),
    .DATA_W    (16),
    .MAX_BURST (MB)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .REQ       (REQ),
    .WE        (WE),
    .ADDR0     (ADDR0),
    .ADDR1     (ADDR1),
    .WDATA0    (WDATA0),
    .WDATA1    (WDATA1),
    .GNT       (GNT),
    .RVALID    (RVALID),
    .RVALID_ID (RVALID_ID),
    .RDATA     (RDATA),
    .RAM_EN    (RAM_EN),
    .RAM_WE    (RAM_WE),
    .RAM_ADDR  (RAM_ADDR),
    .RAM_DIN   (RAM_DIN),
    .RAM_DOUT  (ram_dout)
  );

  function automatic logic [15:0] preload(input logic [11:0] a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Frame RAM: single port, one-cycle registered read, preloaded during reset.
  logic [15:0] mem [4096];
  always @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4096; i++) mem[i] <= preload(12'(i));
      ram_dout <= '0;
    end else if (RAM_EN) begin
      if (RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
      else        ram_dout <= mem[RAM_ADDR];
    end
  end

  // Behavioural model: who owns the RAM, beats taken in this tenure, whom
  // to favour next, pending read return and the expected memory contents.
  logic        m_busy = 1'b0;
  logic        m_who = 1'b0;
  logic        m_pref = 1'b0;
  int          m_beats = 0;
  logic        m_rv = 1'b0;
  logic        m_rv_id = 1'b0;
  logic [15:0] m_rdata = '0;
  logic [1:0]  m_beat_n = 2'b00;
  logic [15:0] gold [4096];

  always @(posedge CLK or negedge RESET_N) begin : model_upd
    logic        beat;
    logic        rd;
    logic [11:0] a;
    logic [15:0] d;
    logic        nb;
    logic        nw;
    int          nbeats;
    if (!RESET_N) begin
      m_busy   <= 1'b0;
      m_who    <= 1'b0;
      m_pref   <= 1'b0;
      m_beats  <= 0;
      m_rv     <= 1'b0;
      m_rv_id  <= 1'b0;
      m_beat_n <= 2'b00;
      for (int i = 0; i < 4096; i++) gold[i] <= preload(12'(i));
    end else begin
      beat = m_busy && REQ[m_who];
      a    = m_who ? ADDR1 : ADDR0;
      d    = m_who ? WDATA1 : WDATA0;
      rd   = beat && !WE[m_who];
      m_rv <= rd;
      if (rd) begin
        m_rv_id <= m_who;
        m_rdata <= gold[a];
      end
      if (beat && WE[m_who]) gold[a] <= d;
      m_beat_n <= {beat && m_who, beat && !m_who};

      nb = m_busy;
      nw = m_who;
      nbeats = m_beats;
      if (!m_busy) begin
        if (REQ != 2'b00) begin
          nb = 1'b1;
          nw = (REQ == 2'b11) ? (FIXED_PRIO ? 1'b0 : m_pref) : REQ[1];
          nbeats = 0;
        end
      end else if (!REQ[m_who]) begin
        nb = REQ[!m_who];
        nw = !m_who;
        nbeats = 0;
      end else if (FIXED_PRIO && m_who && REQ[0]) begin
        nw = 1'b0;
        nbeats = 0;
      end else if (!(FIXED_PRIO && !m_who) && m_beats == MB - 1 && REQ[!m_who]) begin
        nw = !m_who;
        nbeats = 0;
      end else begin
        nbeats = (m_beats >= MB - 1) ? MB - 1 : m_beats + 1;
      end
      if (m_busy && (nb != m_busy || nw != m_who)) m_pref <= !m_who;
      m_busy  <= nb;
      m_who   <= nw;
      m_beats <= nbeats;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge CLK) begin : compare
    logic        eb;
    logic [1:0]  eg;
    logic [11:0] ea;
    logic [15:0] ed;
    eb = m_busy && REQ[m_who];
    eg = m_busy ? (m_who ? 2'b10 : 2'b01) : 2'b00;
    ea = eb ? (m_who ? ADDR1 : ADDR0) : 12'h000;
    ed = eb ? (m_who ? WDATA1 : WDATA0) : 16'h0000;
    chk("m_gnt",      32'(GNT),      32'(eg));
    chk("m_ram_en",   32'(RAM_EN),   32'(eb));
    chk("m_ram_we",   32'(RAM_WE),   32'(eb && WE[m_who]));
    chk("m_ram_addr", 32'(RAM_ADDR), 32'(ea));
    chk("m_ram_din",  32'(RAM_DIN),  32'(ed));
    chk("m_rvalid",   32'(RVALID),   32'(m_rv));
    if (m_rv) begin
      chk("m_rvalid_id", 32'(RVALID_ID), 32'(m_rv_id));
      chk("m_rdata",     32'(RDATA),     32'(m_rdata));
    end
  end

  function automatic logic [11:0] rnd_addr();
    logic [11:0] a;
    a = 12'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) a = a | 12'h800;
    return a;
  endfunction

  int rem [2] = '{0, 0};

  initial begin
    // Reset held with both requesters asking.
    RESET_N = 1'b0;
    REQ = 2'b11;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_gnt",       32'(GNT),       32'h0);
    chk("rst_ram_en",    32'(RAM_EN),    32'h0);
    chk("rst_rvalid",    32'(RVALID),    32'h0);
    chk("rst_rvalid_id", 32'(RVALID_ID), 32'h0);
    step();
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("rst_rel_gnt_idle", 32'(GNT), 32'h0);
    step();
    @(negedge CLK);
    chk("rst_rel_gnt01", 32'(GNT), 32'h1);
    step();
    REQ = 2'b00;
    step();
    step();

    // Single read burst of four beats from the second frame.
    step();
    REQ = 2'b01;
    WE = 2'b00;
    ADDR0 = 12'h800;
    step();
    for (int i = 0; i < 4; i++) begin
      ADDR0 = 12'h800 + 12'(i);
      @(negedge CLK);
      chk("rd_ram_en",   32'(RAM_EN),   32'h1);
      chk("rd_ram_addr", 32'(RAM_ADDR), 32'h800 + 32'(i));
      if (i > 0) begin
        chk("rd_rvalid",    32'(RVALID),    32'h1);
        chk("rd_rvalid_id", 32'(RVALID_ID), 32'h0);
        chk("rd_rdata",     32'(RDATA),     32'(preload(12'h800 + 12'(i - 1))));
      end
      step();
    end
    REQ = 2'b00;
    @(negedge CLK);
    chk("rd_tail_ram_en", 32'(RAM_EN), 32'h0);
    chk("rd_tail_rvalid", 32'(RVALID), 32'h1);
    chk("rd_tail_rdata",  32'(RDATA),  32'(preload(12'h803)));
    step();
    @(negedge CLK);
    chk("rd_done_gnt",    32'(GNT),    32'h0);
    chk("rd_done_rvalid", 32'(RVALID), 32'h0);

`ifndef FRAME_RAM_FIXED_PRIO_EN
    // Burst bound: host arrives at beat 2, blitter gets exactly four beats.
    step();
    REQ = 2'b01;
    ADDR0 = 12'h010;
    for (int b = 0; b < 4; b++) begin
      step();
      if (b == 1) REQ[1] = 1'b1;
      @(negedge CLK);
      chk("bound_gnt0",   32'(GNT),    32'h1);
      chk("bound_ram_en", 32'(RAM_EN), 32'h1);
    end
    for (int h = 0; h < 3; h++) begin
      step();
      @(negedge CLK);
      chk("bound_gnt1", 32'(GNT), 32'h2);
    end
    step();
    REQ[1] = 1'b0;
    @(negedge CLK);
    chk("bound_rel_gnt",    32'(GNT),    32'h2);
    chk("bound_rel_ram_en", 32'(RAM_EN), 32'h0);
    step();
    @(negedge CLK);
    chk("bound_back_gnt0", 32'(GNT), 32'h1);
    step();
    REQ = 2'b00;
    step();
`else
    // Fixed priority: blitter preempts a streaming host and keeps the RAM.
    step();
    REQ = 2'b10;
    ADDR1 = 12'h040;
    step();
    @(negedge CLK);
    chk("fp_gnt1", 32'(GNT), 32'h2);
    step();
    REQ[0] = 1'b1;
    @(negedge CLK);
    chk("fp_last_host_gnt",  32'(GNT),    32'h2);
    chk("fp_last_host_beat", 32'(RAM_EN), 32'h1);
    step();
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      chk("fp_hold_gnt0", 32'(GNT),    32'h1);
      chk("fp_hold_beat", 32'(RAM_EN), 32'h1);
      step();
    end
    REQ[0] = 1'b0;
    @(negedge CLK);
    chk("fp_rel_ram_en", 32'(RAM_EN), 32'h0);
    step();
    @(negedge CLK);
    chk("fp_back_gnt1", 32'(GNT), 32'h2);
    step();
    REQ = 2'b00;
    step();
`endif

    // Release mid-burst with nobody else waiting.
    step();
    REQ = 2'b10;
    WE = 2'b00;
    ADDR1 = 12'h7FF;
    step();
    @(negedge CLK);
    chk("rel_gnt1",   32'(GNT),    32'h2);
    chk("rel_ram_en", 32'(RAM_EN), 32'h1);
    step();
    step();
    REQ[1] = 1'b0;
    @(negedge CLK);
    chk("rel_drop_ram_en", 32'(RAM_EN), 32'h0);
    chk("rel_drop_gnt",    32'(GNT),    32'h2);
    step();
    @(negedge CLK);
    chk("rel_idle_gnt", 32'(GNT), 32'h0);

    // Host writes 0xBEEF to 0x123, blitter reads it back.
    step();
    REQ = 2'b10;
    WE = 2'b10;
    ADDR1 = 12'h123;
    WDATA1 = 16'hBEEF;
    step();
    @(negedge CLK);
    chk("wr_gnt",      32'(GNT),      32'h2);
    chk("wr_ram_we",   32'(RAM_WE),   32'h1);
    chk("wr_ram_addr", 32'(RAM_ADDR), 32'h123);
    chk("wr_ram_din",  32'(RAM_DIN),  32'hBEEF);
    step();
    REQ = 2'b01;
    WE = 2'b00;
    ADDR0 = 12'h123;
    @(negedge CLK);
    chk("wr_rel_ram_en", 32'(RAM_EN), 32'h0);
    step();
    @(negedge CLK);
    chk("rb_gnt",    32'(GNT),    32'h1);
    chk("rb_ram_we", 32'(RAM_WE), 32'h0);
    step();
    REQ = 2'b00;
    @(negedge CLK);
    chk("rb_rvalid",    32'(RVALID),    32'h1);
    chk("rb_rvalid_id", 32'(RVALID_ID), 32'h0);
    chk("rb_rdata",     32'(RDATA),     32'hBEEF);
    step();

    // Randomized traffic: each requester asks for a random burst length and
    // holds REQ until it has taken that many beats, sometimes quitting early
    // while it owns the RAM.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int n = 0; n < 2; n++) begin
        if (REQ[n]) begin
          if (m_beat_n[n]) rem[n] = rem[n] - 1;
          if (rem[n] <= 0) REQ[n] = 1'b0;
          else if (m_busy && m_who == 1'(n) && $urandom_range(0, 99) < 5) REQ[n] = 1'b0;
        end else if ($urandom_range(0, 99) < 25) begin
          REQ[n] = 1'b1;
          rem[n] = int'($urandom_range(1, 10));
        end
      end
      WE = 2'($urandom);
      ADDR0 = rnd_addr();
      ADDR1 = rnd_addr();
      WDATA0 = 16'($urandom);
      WDATA1 = 16'($urandom);
    end
    REQ = 2'b00;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
